// File: rtl/acc_cpu_mc_if.sv
// Instruction and data memory handshake bundle for acc_cpu_mc.
// The master side is the CPU core and the slave side is the memory system.
interface acc_cpu_mc_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [AW+2:0] imem_data;
  logic          imem_ack;

  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;

  modport master (
    output imem_req, imem_addr,
    input  imem_data, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_data, imem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/acc_cpu_mc.sv
// Multicycle accumulator CPU: FSM-sequenced fetch/execute/memory with req/ack memories.
// Memory requests are decoded purely from state so reset drops them asynchronously.
module acc_cpu_mc #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  acc_cpu_mc_if.master  bus,
  output logic [DW-1:0] acc_o,
  output logic [1:0]    flags_o,
  output logic [AW-1:0] pc_o,
  output logic [AW+2:0] ir_o,
  output logic          retire_o,
  output logic          halted_o
);
  localparam int unsigned IW = AW + 3;
  localparam int unsigned MW = (AW > DW) ? AW : DW;

  typedef enum logic [2:0] {
    StBoot, StFetch, StExec, StMemRd, StMemWr, StHalt
  } state_e;

  typedef enum logic [2:0] {
    OpLda = 3'd0, OpSta = 3'd1, OpAdd = 3'd2, OpSub = 3'd3,
    OpLdi = 3'd4, OpJmp = 3'd5, OpJz  = 3'd6, OpHlt = 3'd7
  } op_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          c_q, c_d;
  logic          z_q, z_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          retire_q, retire_d;

  op_e           op;
  logic [AW-1:0] operand;
  logic [MW-1:0] imm_wide;
  logic [DW-1:0] imm;
  logic [DW:0]   sum;
  logic [DW:0]   diff;

  assign op       = op_e'(ir_q[IW-1:AW]);
  assign operand  = ir_q[AW-1:0];
  // Zero-extend or truncate the operand to the accumulator width.
  assign imm_wide = MW'(operand);
  assign imm      = imm_wide[DW-1:0];
  assign sum      = {1'b0, acc_q} + {1'b0, bus.dmem_rdata};
  // Top bit of the widened difference is the unsigned borrow.
  assign diff     = {1'b0, acc_q} - {1'b0, bus.dmem_rdata};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    c_d      = c_q;
    z_d      = z_q;
    ir_d     = ir_q;
    retire_d = 1'b0;

    unique case (state_q)
      StBoot: state_d = StFetch;

      StFetch: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + 1'b1;
          state_d = StExec;
        end
      end

      StExec: begin
        unique case (op)
          OpLdi: begin
            acc_d    = imm;
            z_d      = (imm == '0);
            c_d      = 1'b0;
            retire_d = 1'b1;
            state_d  = StFetch;
          end
          OpJmp: begin
            pc_d     = operand;
            retire_d = 1'b1;
            state_d  = StFetch;
          end
          OpJz: begin
            if (z_q) pc_d = operand;
            retire_d = 1'b1;
            state_d  = StFetch;
          end
          OpLda, OpAdd, OpSub: state_d = StMemRd;
          OpSta:               state_d = StMemWr;
          OpHlt:               state_d = StHalt;
        endcase
      end

      StMemRd: begin
        if (bus.dmem_ack) begin
          case (op)
            OpAdd: begin
              acc_d = sum[DW-1:0];
              c_d   = sum[DW];
            end
            OpSub: begin
              acc_d = diff[DW-1:0];
              c_d   = diff[DW];
            end
            default: begin
              acc_d = bus.dmem_rdata;
              c_d   = 1'b0;
            end
          endcase
          z_d      = (acc_d == '0);
          retire_d = 1'b1;
          state_d  = StFetch;
        end
      end

      StMemWr: begin
        if (bus.dmem_ack) begin
          retire_d = 1'b1;
          state_d  = StFetch;
        end
      end

      StHalt: state_d = StHalt;

      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StBoot;
      pc_q     <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      ir_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      z_q      <= z_d;
      ir_q     <= ir_d;
      retire_q <= retire_d;
    end
  end

  assign bus.imem_req   = (state_q == StFetch);
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = (state_q == StMemRd) || (state_q == StMemWr);
  assign bus.dmem_we    = (state_q == StMemWr);
  assign bus.dmem_addr  = operand;
  assign bus.dmem_wdata = acc_q;

  assign acc_o    = acc_q;
  assign flags_o  = {c_q, z_q};
  assign pc_o     = pc_q;
  assign ir_o     = ir_q;
  assign retire_o = retire_q;
  assign halted_o = (state_q == StHalt);
endmodule

// File: tb/tb_acc_cpu_mc.sv
// Self-checking bench for acc_cpu_mc: wait-state memory responders plus an
// instruction-level interpreter that predicts state, timing and memory contents.
module tb_acc_cpu_mc;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned IW = AW + 3;
  localparam int unsigned NW = 1 << AW;

  localparam logic [2:0] OP_LDA = 3'd0, OP_STA = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
  localparam logic [2:0] OP_LDI = 3'd4, OP_JMP = 3'd5, OP_JZ  = 3'd6, OP_HLT = 3'd7;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [DW-1:0] acc_o;
  logic [1:0]    flags_o;
  logic [AW-1:0] pc_o;
  logic [IW-1:0] ir_o;
  logic          retire_o;
  logic          halted_o;

  always #5 clk = ~clk;

  acc_cpu_mc_if #(.DW(DW), .AW(AW)) bus ();

  acc_cpu_mc #(.DW(DW), .AW(AW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .bus      (bus),
    .acc_o    (acc_o),
    .flags_o  (flags_o),
    .pc_o     (pc_o),
    .ir_o     (ir_o),
    .retire_o (retire_o),
    .halted_o (halted_o)
  );

  // Memories and wait-state responders
  logic [IW-1:0] imem [NW];
  logic [DW-1:0] dmem [NW];
  int            iwait = 0;
  int            dwait = 0;
  int            icnt, dcnt;
  int            wr_cnt = 0;
  bit            force_ack = 1'b0;

  assign bus.imem_data  = imem[bus.imem_addr];
  assign bus.dmem_rdata = dmem[bus.dmem_addr];
  assign bus.imem_ack   = force_ack | (bus.imem_req && (icnt >= iwait));
  assign bus.dmem_ack   = force_ack | (bus.dmem_req && (dcnt >= dwait));

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
      dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
      if (bus.dmem_req && bus.dmem_we && bus.dmem_ack) begin
        dmem[bus.dmem_addr] <= bus.dmem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  // Architectural reference model
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_acc;
  logic          m_c, m_z;
  logic [IW-1:0] m_ir;
  logic [DW-1:0] m_dmem [NW];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [IW-1:0] ins(input logic [2:0] op, input int a);
    return {op, AW'(a)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < int'(NW); i++) begin
      imem[i] = ins(OP_HLT, 0);
      dmem[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    m_pc  = '0;
    m_acc = '0;
    m_c   = 1'b0;
    m_z   = 1'b0;
    m_ir  = '0;
    for (int i = 0; i < int'(NW); i++) m_dmem[i] = dmem[i];
    rst_ni = 1'b1;
  endtask

  task automatic model_step(output logic [2:0] op, output int exp_cyc);
    logic [AW-1:0] a;
    int t;
    m_ir = imem[m_pc];
    op   = m_ir[IW-1:AW];
    a    = m_ir[AW-1:0];
    m_pc = m_pc + 1'b1;
    exp_cyc = 2 + iwait;
    case (op)
      OP_LDA: begin
        m_acc = m_dmem[a]; m_c = 1'b0; m_z = (m_acc == 0); exp_cyc += 1 + dwait;
      end
      OP_STA: begin
        m_dmem[a] = m_acc; exp_cyc += 1 + dwait;
      end
      OP_ADD: begin
        t = int'(m_acc) + int'(m_dmem[a]);
        m_c = (t >= (1 << DW)); m_acc = DW'(t); m_z = (m_acc == 0); exp_cyc += 1 + dwait;
      end
      OP_SUB: begin
        m_c = (m_acc < m_dmem[a]); m_acc = m_acc - m_dmem[a]; m_z = (m_acc == 0);
        exp_cyc += 1 + dwait;
      end
      OP_LDI: begin
        m_acc = DW'(a); m_c = 1'b0; m_z = (m_acc == 0);
      end
      OP_JMP: m_pc = a;
      OP_JZ:  if (m_z) m_pc = a;
      default: ;
    endcase
  endtask

  // Runs the core in lock-step with the model until max_ret retires or a halt.
  task automatic run_prog(input int max_ret, input int budget, input bit from_reset,
                          output int n_ret, output bit hit_halt);
    int cyc;
    int exp_cyc;
    bit first;
    bit stop;
    logic [2:0] op;
    n_ret = 0; hit_halt = 1'b0; cyc = 0; first = from_reset; stop = 1'b0;
    for (int t = 0; t < budget && !stop; t++) begin
      @(negedge clk);
      cyc++;
      if (retire_o || halted_o) begin
        model_step(op, exp_cyc);
        if (first) exp_cyc += 1;
        n_checks++;
        if ((op == OP_HLT) ? (halted_o !== 1'b1 || retire_o !== 1'b0)
                           : (retire_o !== 1'b1 || halted_o !== 1'b0)) begin
          n_fail++;
          $display("FAIL run_status: ir=%h retire=%b halted=%b expected op=%0d",
                   m_ir, retire_o, halted_o, op);
        end
        n_checks++;
        if (cyc != exp_cyc) begin
          n_fail++;
          $display("FAIL run_cycles: ir=%h took %0d cycles, expected %0d", m_ir, cyc, exp_cyc);
        end
        n_checks++;
        if (acc_o !== m_acc || flags_o !== {m_c, m_z} || pc_o !== m_pc || ir_o !== m_ir) begin
          n_fail++;
          $display("FAIL run_state: acc=%h flags=%b pc=%h ir=%h, expected acc=%h flags=%b pc=%h ir=%h",
                   acc_o, flags_o, pc_o, ir_o, m_acc, {m_c, m_z}, m_pc, m_ir);
        end
        cyc = 0; first = 1'b0;
        if (op == OP_HLT) hit_halt = 1'b1; else n_ret++;
        if (halted_o || hit_halt || n_ret >= max_ret) stop = 1'b1;
      end
    end
    n_checks++;
    if (!stop) begin
      n_fail++;
      $display("FAIL run_timeout: %0d retires in %0d cycles, wanted %0d", n_ret, budget, max_ret);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    force_ack = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({bus.imem_req, bus.dmem_req, bus.dmem_we, retire_o, halted_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req/we/retire/halted=%b expected 00000",
               {bus.imem_req, bus.dmem_req, bus.dmem_we, retire_o, halted_o});
    end
    n_checks++;
    if (acc_o !== '0 || flags_o !== 2'b00 || pc_o !== '0 || ir_o !== '0 ||
        bus.imem_addr !== '0 || bus.dmem_addr !== '0 || bus.dmem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: acc=%h flags=%b pc=%h ir=%h expected all zero",
               acc_o, flags_o, pc_o, ir_o);
    end
    force_ack = 1'b0;
    rst_ni = 1'b1;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_boot: imem_req=%b right after release, expected 0", bus.imem_req);
    end
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_first_fetch: req=%b addr=%h expected 1/00", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_add_carry();
    int n; bit h;
    clear_mem();
    iwait = 0; dwait = 0;
    imem[0] = ins(OP_LDI, 5);
    imem[1] = ins(OP_ADD, 3);
    dmem[3] = 8'hFC;
    do_reset();
    run_prog(2, 50, 1'b1, n, h);
    n_checks++;
    if (acc_o !== 8'h01 || flags_o !== 2'b10) begin
      n_fail++;
      $display("FAIL add_carry: acc=%h flags=%b expected 01/10", acc_o, flags_o);
    end
    run_prog(1, 20, 1'b0, n, h);
    n_checks++;
    if (!h) begin
      n_fail++;
      $display("FAIL add_halt: halted=%b expected 1", h);
    end
  endtask

  task automatic test_sub_jz();
    int n; bit h;
    clear_mem();
    iwait = 0; dwait = 0;
    dmem[4]  = 8'h01;
    imem[0]  = ins(OP_LDI, 1);
    imem[1]  = ins(OP_SUB, 4);
    imem[2]  = ins(OP_JZ, 9);
    imem[9]  = ins(OP_LDI, 2);
    imem[10] = ins(OP_SUB, 4);
    imem[11] = ins(OP_JZ, 20);
    imem[12] = ins(OP_LDI, 0);
    imem[13] = ins(OP_SUB, 4);
    do_reset();
    run_prog(3, 50, 1'b1, n, h);
    n_checks++;
    if (pc_o !== 5'd9 || acc_o !== 8'h00 || flags_o !== 2'b01) begin
      n_fail++;
      $display("FAIL jz_taken: pc=%h acc=%h flags=%b expected 09/00/01", pc_o, acc_o, flags_o);
    end
    run_prog(3, 50, 1'b0, n, h);
    n_checks++;
    if (pc_o !== 5'd12 || acc_o !== 8'h01 || flags_o !== 2'b00) begin
      n_fail++;
      $display("FAIL jz_not_taken: pc=%h acc=%h flags=%b expected 0c/01/00", pc_o, acc_o, flags_o);
    end
    run_prog(2, 50, 1'b0, n, h);
    n_checks++;
    if (acc_o !== 8'hFF || flags_o !== 2'b10) begin
      n_fail++;
      $display("FAIL sub_borrow: acc=%h flags=%b expected ff/10", acc_o, flags_o);
    end
  endtask

  task automatic test_sta_wait();
    int n; bit h; int held; int wr0; bit bad;
    clear_mem();
    iwait = 0; dwait = 3;
    imem[0] = ins(OP_LDI, 26);
    imem[1] = ins(OP_STA, 7);
    do_reset();
    run_prog(1, 50, 1'b1, n, h);
    wr0 = wr_cnt; held = 0; bad = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus.dmem_req) begin
        held++;
        if (bus.dmem_we !== 1'b1 || bus.dmem_addr !== 5'd7 || bus.dmem_wdata !== 8'd26) bad = 1'b1;
      end
      if (retire_o) break;
    end
    n_checks++;
    if (held != 4 || bad) begin
      n_fail++;
      $display("FAIL sta_hold: req held %0d cycles unstable=%b, expected 4/0", held, bad);
    end
    n_checks++;
    if (wr_cnt - wr0 != 1 || dmem[7] !== 8'd26) begin
      n_fail++;
      $display("FAIL sta_write: %0d writes dmem[7]=%h, expected 1/1a", wr_cnt - wr0, dmem[7]);
    end
    n_checks++;
    if (acc_o !== 8'd26 || flags_o !== 2'b00 || retire_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sta_state: acc=%h flags=%b retire=%b expected 1a/00/1",
               acc_o, flags_o, retire_o);
    end
    dwait = 0;
  endtask

  task automatic test_jmp_wrap();
    int n; bit h;
    clear_mem();
    iwait = 0; dwait = 0;
    imem[0]  = ins(OP_JMP, 31);
    imem[31] = ins(OP_LDI, 2);
    do_reset();
    run_prog(2, 50, 1'b1, n, h);
    n_checks++;
    if (pc_o !== '0 || acc_o !== 8'd2 || bus.imem_req !== 1'b1 || bus.imem_addr !== '0) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h acc=%h req=%b addr=%h expected 00/02/1/00",
               pc_o, acc_o, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_imem_wait();
    bit bad;
    clear_mem();
    iwait = 2; dwait = 0;
    imem[0] = ins(OP_LDI, 17);
    do_reset();
    bad = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      if (bus.imem_req !== 1'b1 || ir_o !== '0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL ir_stall: ir=%h req=%b while stalled, expected 00/1", ir_o, bus.imem_req);
    end
    @(negedge clk);
    n_checks++;
    if (ir_o !== ins(OP_LDI, 17) || bus.imem_req !== 1'b0 || pc_o !== 5'd1) begin
      n_fail++;
      $display("FAIL ir_load: ir=%h req=%b pc=%h expected %h/0/01",
               ir_o, bus.imem_req, pc_o, ins(OP_LDI, 17));
    end
    @(negedge clk);
    n_checks++;
    if (acc_o !== 8'd17 || retire_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ldi_after_wait: acc=%h retire=%b expected 11/1", acc_o, retire_o);
    end
    iwait = 0;
  endtask

  task automatic test_halt();
    int n; bit h; int reqs;
    clear_mem();
    iwait = 0; dwait = 0;
    imem[0] = ins(OP_LDI, 3);
    do_reset();
    run_prog(5, 50, 1'b1, n, h);
    reqs = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.imem_req || bus.dmem_req || !halted_o || retire_o) reqs++;
    end
    n_checks++;
    if (!h || reqs != 0) begin
      n_fail++;
      $display("FAIL halt_quiet: halted=%b %0d active cycles, expected 1/0", h, reqs);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit h;
    clear_mem();
    iwait = 0; dwait = 1000;
    imem[0] = ins(OP_LDI, 3);
    imem[1] = ins(OP_LDA, 5);
    dmem[5] = 8'h5A;
    do_reset();
    run_prog(1, 50, 1'b1, n, h);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_rd: dmem_req=%b we=%b expected 1/0", bus.dmem_req, bus.dmem_we);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (bus.dmem_req !== 1'b0 || acc_o !== '0 || pc_o !== '0 || ir_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: dmem_req=%b acc=%h pc=%h ir=%h expected all zero",
               bus.dmem_req, acc_o, pc_o, ir_o);
    end
    dwait = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== '0) begin
      n_fail++;
      $display("FAIL refetch: imem_req=%b addr=%h expected 1/00", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    int n; bit h; logic [2:0] op;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < int'(NW); i++) begin
        op = ($urandom_range(0, 15) == 0) ? OP_HLT : 3'($urandom_range(0, 6));
        imem[i] = ins(op, int'($urandom_range(0, NW - 1)));
        dmem[i] = DW'($urandom);
      end
      iwait = int'($urandom_range(0, 2));
      dwait = int'($urandom_range(0, 2));
      do_reset();
      run_prog(40, 3000, 1'b1, n, h);
      for (int i = 0; i < int'(NW); i++) begin
        n_checks++;
        if (dmem[i] !== m_dmem[i]) begin
          n_fail++;
          $display("FAIL rand_dmem: run %0d dmem[%0d]=%h expected %h", r, i, dmem[i], m_dmem[i]);
        end
      end
    end
    iwait = 0; dwait = 0;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_add_carry();
    test_sub_jz();
    test_sta_wait();
    test_jmp_wrap();
    test_imem_wait();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
